// File: rtl/divide_arbiter.sv
// Round-robin front end sharing one self-timed req/fin divider among NReq clocked requesters.
// Handles divide-by-zero locally and aborts a stuck divider after TimeoutCycles.
module divide_arbiter #(
  parameter int NReq          = 4,
  parameter int AWidth        = 32,
  parameter int BWidth        = 32,
  parameter int TimeoutCycles = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NReq-1:0]          cpu_req,
  input  logic [NReq*AWidth-1:0]   cpu_a,
  input  logic [NReq*BWidth-1:0]   cpu_b,
  output logic [NReq-1:0]          cpu_ack,
  output logic [AWidth-1:0]        cpu_s,
  output logic [BWidth-1:0]        cpu_mod,
  output logic                     cpu_dz,
  output logic                     cpu_err,
  output logic                     busy,
  output logic                     div_req,
  output logic [AWidth-1:0]        div_a,
  output logic [BWidth-1:0]        div_b,
  input  logic                     div_fin,
  input  logic [AWidth-1:0]        div_s,
  input  logic [BWidth-1:0]        div_mod
);

  localparam int IW = (NReq > 1) ? $clog2(NReq) : 1;
  localparam int CW = $clog2(TimeoutCycles);
  localparam logic [CW-1:0] TMAX = CW'(TimeoutCycles - 1);

  typedef enum logic [2:0] {IDLE, WAIT_FIN, WAIT_RTZ, DZ, DONE} state_t;

  state_t              state;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       idx;
  logic [CW-1:0]       cnt;
  logic                fin_p0;
  logic                fin_s;
  logic [1:0]          settle;
  logic [AWidth-1:0]   res_s;
  logic [BWidth-1:0]   res_mod;
  logic                res_dz;
  logic                res_err;

  logic [IW-1:0]       grant;
  logic [AWidth-1:0]   sel_a;
  logic [BWidth-1:0]   sel_b;
  logic [NReq-1:0]     ack_vec;

  // First set request at or above base, wrapping around.
  function automatic logic [IW-1:0] rr_pick(input logic [NReq-1:0] req,
                                            input logic [IW-1:0]   base);
    logic [IW-1:0] c;
    logic [IW-1:0] pick;
    logic          found;
    c     = base;
    pick  = base;
    found = 1'b0;
    for (int k = 0; k < NReq; k++) begin
      if (!found && req[c]) begin
        pick  = c;
        found = 1'b1;
      end
      c = (c == IW'(NReq - 1)) ? '0 : c + 1'b1;
    end
    return pick;
  endfunction

  // Divide-by-zero remainder: dividend zero-extended or truncated to BWidth.
  function automatic logic [BWidth-1:0] fit_mod(input logic [AWidth-1:0] a);
    logic [BWidth-1:0] r;
    r = '0;
    for (int i = 0; i < BWidth && i < AWidth; i++) r[i] = a[i];
    return r;
  endfunction

  always_comb begin
    grant   = rr_pick(cpu_req, ptr);
    sel_a   = '0;
    sel_b   = '0;
    ack_vec = '0;
    for (int i = 0; i < NReq; i++) begin
      if (grant == IW'(i)) begin
        sel_a = cpu_a[i*AWidth +: AWidth];
        sel_b = cpu_b[i*BWidth +: BWidth];
      end
      ack_vec[i] = (idx == IW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      idx     <= '0;
      cnt     <= '0;
      fin_p0  <= 1'b0;
      fin_s   <= 1'b0;
      settle  <= '0;
      res_s   <= '0;
      res_mod <= '0;
      res_dz  <= 1'b0;
      res_err <= 1'b0;
      div_req <= 1'b0;
      div_a   <= '0;
      div_b   <= '0;
      cpu_ack <= '0;
      cpu_s   <= '0;
      cpu_mod <= '0;
      cpu_dz  <= 1'b0;
      cpu_err <= 1'b0;
      busy    <= 1'b0;
    end else begin
      fin_p0 <= div_fin;
      fin_s  <= fin_p0;
      // Hold off issue until the synchroniser reflects the real fin level after reset.
      if (!settle[1]) settle <= settle + 2'd1;
      cpu_ack <= '0;
      cpu_s   <= '0;
      cpu_mod <= '0;
      cpu_dz  <= 1'b0;
      cpu_err <= 1'b0;
      case (state)
        IDLE: begin
          if (|cpu_req && !fin_s && settle[1]) begin
            idx     <= grant;
            div_a   <= sel_a;
            div_b   <= sel_b;
            res_dz  <= 1'b0;
            res_err <= 1'b0;
            busy    <= 1'b1;
            if (sel_b == '0) begin
              state <= DZ;
            end else begin
              div_req <= 1'b1;
              cnt     <= '0;
              state   <= WAIT_FIN;
            end
          end
        end
        WAIT_FIN: begin
          // fin is checked first so it wins over a simultaneous timeout.
          if (fin_s) begin
            res_s   <= div_s;
            res_mod <= div_mod;
            div_req <= 1'b0;
            cnt     <= '0;
            state   <= WAIT_RTZ;
          end else if (cnt == TMAX) begin
            res_s   <= '0;
            res_mod <= '0;
            res_err <= 1'b1;
            div_req <= 1'b0;
            cnt     <= '0;
            state   <= WAIT_RTZ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_RTZ: begin
          if (!fin_s) begin
            state <= DONE;
          end else if (cnt == TMAX) begin
            res_err <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DZ: begin
          res_s   <= '1;
          res_mod <= fit_mod(div_a);
          res_dz  <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          cpu_ack <= ack_vec;
          cpu_s   <= res_s;
          cpu_mod <= res_mod;
          cpu_dz  <= res_dz;
          cpu_err <= res_err;
          ptr     <= (idx == IW'(NReq - 1)) ? '0 : idx + 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divide_arbiter.sv
// Directed bench for divide_arbiter: vector table plus hand-timed multi-cycle sequences.
module tb_divide_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   cpu_req;
  logic [N*W-1:0] cpu_a;
  logic [N*W-1:0] cpu_b;
  logic [N-1:0]   cpu_ack;
  logic [W-1:0]   cpu_s;
  logic [W-1:0]   cpu_mod;
  logic           cpu_dz;
  logic           cpu_err;
  logic           busy;
  logic           div_req;
  logic [W-1:0]   div_a;
  logic [W-1:0]   div_b;
  logic           div_fin;
  logic [W-1:0]   div_s;
  logic [W-1:0]   div_mod;

  logic           div_auto;
  logic           auto_fin, man_fin;
  logic [W-1:0]   auto_s, auto_mod, man_s, man_mod;

  assign div_fin = div_auto ? auto_fin : man_fin;
  assign div_s   = div_auto ? auto_s   : man_s;
  assign div_mod = div_auto ? auto_mod : man_mod;

  int n_cmp = 0;
  int n_bad = 0;

  divide_arbiter #(.NReq(N), .AWidth(W), .BWidth(W), .TimeoutCycles(16)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_a(cpu_a), .cpu_b(cpu_b),
    .cpu_ack(cpu_ack), .cpu_s(cpu_s), .cpu_mod(cpu_mod), .cpu_dz(cpu_dz),
    .cpu_err(cpu_err), .busy(busy), .div_req(div_req), .div_a(div_a),
    .div_b(div_b), .div_fin(div_fin), .div_s(div_s), .div_mod(div_mod)
  );

  always #5 clk = ~clk;

  // Behavioural self-timed divider: 4-phase req/fin with arbitrary delays.
  initial begin
    auto_fin = 1'b0;
    auto_s   = '0;
    auto_mod = '0;
    forever begin
      wait (div_req === 1'b1 && div_auto === 1'b1);
      #23;
      if (div_b != 0) begin
        auto_s   = div_a / div_b;
        auto_mod = div_a % div_b;
      end
      auto_fin = 1'b1;
      wait (div_req === 1'b0);
      #17;
      auto_fin = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         idx;
    logic [W-1:0] a, b, s, m;
    logic       dz;
  } vec_t;

  vec_t vecs[6];
  logic [W-1:0] rr_s[4] = '{32'd3, 32'd3, 32'd4, 32'd4};
  logic [W-1:0] rr_m[4] = '{32'd1, 32'd2, 32'd0, 32'd1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic start_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    cpu_a[i*W +: W] = a;
    cpu_b[i*W +: W] = b;
    cpu_req[i]      = 1'b1;
  endtask

  task automatic wait_ack(output logic [N-1:0] ack, output logic [W-1:0] s,
                          output logic [W-1:0] m, output logic dz, output logic err,
                          output logic dr, output logic [W-1:0] sa, output logic [W-1:0] sb);
    ack = '0; s = '0; m = '0; dz = 1'b0; err = 1'b0; dr = 1'b0; sa = '0; sb = '0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (div_req) begin
        dr = 1'b1;
        sa = div_a;
        sb = div_b;
      end
      if (cpu_ack != '0) begin
        ack = cpu_ack; s = cpu_s; m = cpu_mod; dz = cpu_dz; err = cpu_err;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL ack_timeout: got no ack, want ack within 400 cycles");
  endtask

  task automatic wait_div_req_pos(output logic found);
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      if (div_req) begin
        found = 1'b1;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL div_req_timeout: got div_req=0, want 1 within 50 cycles");
  endtask

  logic [N-1:0] ack;
  logic [W-1:0] s, m, sa, sb;
  logic         dz, err, dr, found;
  int           hi;

  initial begin
    vecs[0] = '{0, 32'd100,        32'd7,    32'd14,       32'd2,     1'b0};
    vecs[1] = '{1, 32'd1000,       32'd33,   32'd30,       32'd10,    1'b0};
    vecs[2] = '{2, 32'hFFFF_FFFF,  32'd1,    32'hFFFF_FFFF, 32'd0,    1'b0};
    vecs[3] = '{3, 32'd5,          32'd9,    32'd0,        32'd5,     1'b0};
    vecs[4] = '{2, 32'h1234,       32'd0,    32'hFFFF_FFFF, 32'h1234, 1'b1};
    vecs[5] = '{1, 32'hDEAD_BEEF,  32'h10,   32'h0DEA_DBEE, 32'hF,    1'b0};

    rst_n    = 1'b0;
    cpu_req  = '0;
    cpu_a    = '0;
    cpu_b    = '0;
    div_auto = 1'b1;
    man_fin  = 1'b0;
    man_s    = '0;
    man_mod  = '0;

    #2;
    check("rst cpu_ack", 64'(cpu_ack), 64'd0);
    check("rst div_req", 64'(div_req), 64'd0);
    check("rst busy",    64'(busy),    64'd0);
    check("rst cpu_s",   64'(cpu_s),   64'd0);
    check("rst div_a",   64'(div_a),   64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Round robin with all requests held: grant order 0,1,2,3,0.
    for (int i = 0; i < N; i++) start_req(i, W'(i + 10), 32'd3);
    for (int i = 0; i < 5; i++) begin
      wait_ack(ack, s, m, dz, err, dr, sa, sb);
      check($sformatf("rr%0d ack", i), 64'(ack), 64'(1) << (i % N));
      check($sformatf("rr%0d s", i),   64'(s),   64'(rr_s[i % N]));
      check($sformatf("rr%0d mod", i), 64'(m),   64'(rr_m[i % N]));
    end
    cpu_req = '0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      start_req(vecs[i].idx, vecs[i].a, vecs[i].b);
      wait_ack(ack, s, m, dz, err, dr, sa, sb);
      cpu_req = '0;
      check($sformatf("v%0d ack", i), 64'(ack), 64'(1) << vecs[i].idx);
      check($sformatf("v%0d s", i),   64'(s),   64'(vecs[i].s));
      check($sformatf("v%0d mod", i), 64'(m),   64'(vecs[i].m));
      check($sformatf("v%0d dz", i),  64'(dz),  64'(vecs[i].dz));
      check($sformatf("v%0d err", i), 64'(err), 64'd0);
      if (vecs[i].dz) begin
        check($sformatf("v%0d div_req", i), 64'(dr), 64'd0);
      end else begin
        check($sformatf("v%0d div_a", i), 64'(sa), 64'(vecs[i].a));
        check($sformatf("v%0d div_b", i), 64'(sb), 64'(vecs[i].b));
      end
      @(negedge clk);
      check($sformatf("v%0d ack_clr", i), 64'(cpu_ack), 64'd0);
    end

    // Divide-by-zero latency: ack exactly two edges after the sampling edge.
    start_req(2, 32'h1234, 32'd0);
    @(negedge clk);
    check("dz busy",  64'(busy),    64'd1);
    check("dz ack+0", 64'(cpu_ack), 64'd0);
    @(negedge clk);
    check("dz ack+1", 64'(cpu_ack), 64'd0);
    @(negedge clk);
    cpu_req = '0;
    check("dz ack+2", 64'(cpu_ack), 64'h4);
    check("dz s",     64'(cpu_s),   64'hFFFF_FFFF);
    check("dz mod",   64'(cpu_mod), 64'h1234);
    check("dz flag",  64'(cpu_dz),  64'd1);
    check("dz div_req", 64'(div_req), 64'd0);
    @(negedge clk);

    // Timeout: divider never answers.
    div_auto = 1'b0;
    start_req(1, 32'd50, 32'd5);
    hi = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (div_req) break;
    end
    while (div_req && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    check("to div_req_cycles", 64'(hi), 64'd16);
    wait_ack(ack, s, m, dz, err, dr, sa, sb);
    cpu_req = '0;
    check("to ack", 64'(ack), 64'h2);
    check("to err", 64'(err), 64'd1);
    check("to s",   64'(s),   64'd0);
    check("to mod", 64'(m),   64'd0);
    check("to dz",  64'(dz),  64'd0);
    @(negedge clk);
    div_auto = 1'b1;
    start_req(1, 32'd50, 32'd5);
    wait_ack(ack, s, m, dz, err, dr, sa, sb);
    cpu_req = '0;
    check("to next ack", 64'(ack), 64'h2);
    check("to next s",   64'(s),   64'd10);
    check("to next err", 64'(err), 64'd0);
    @(negedge clk);

    // fin first seen on the same edge the timeout expires: fin wins.
    div_auto = 1'b0;
    start_req(0, 32'd83, 32'd8);
    wait_div_req_pos(found);
    if (found) begin
      repeat (13) @(posedge clk);
      #2;
      man_s   = 32'd10;
      man_mod = 32'd3;
      man_fin = 1'b1;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (!div_req) break;
      end
      man_fin = 1'b0;
    end
    wait_ack(ack, s, m, dz, err, dr, sa, sb);
    cpu_req = '0;
    check("sim ack", 64'(ack), 64'h1);
    check("sim s",   64'(s),   64'd10);
    check("sim mod", 64'(m),   64'd3);
    check("sim err", 64'(err), 64'd0);
    @(negedge clk);

    // Reset in WAIT_FIN with fin held high; the pending request waits for fin to return to zero.
    start_req(3, 32'd9, 32'd2);
    wait_div_req_pos(found);
    man_fin = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid rst div_req", 64'(div_req), 64'd0);
    check("mid rst busy",    64'(busy),    64'd0);
    check("mid rst div_a",   64'(div_a),   64'd0);
    check("mid rst div_b",   64'(div_b),   64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("fin_hi%0d div_req", k), 64'(div_req), 64'd0);
    end
    man_fin = 1'b0;
    @(negedge clk);
    check("rtz+1 div_req", 64'(div_req), 64'd0);
    @(negedge clk);
    check("rtz+2 div_req", 64'(div_req), 64'd0);
    @(negedge clk);
    check("rtz+3 div_req", 64'(div_req), 64'd1);
    check("rtz+3 div_a",   64'(div_a),   64'd9);
    div_auto = 1'b1;
    wait_ack(ack, s, m, dz, err, dr, sa, sb);
    cpu_req = '0;
    check("post rst ack", 64'(ack), 64'h8);
    check("post rst s",   64'(s),   64'd4);
    check("post rst mod", 64'(m),   64'd1);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
